proc_ctrl_fsm: RTL
==================

# proc_ctrl_fsm

Parametrised control unit for the multi-cycle simple processor. It adds instruction fetch from memory through the PC register, load/store with a memory wait handshake, an AND operation, and conditional branch on the datapath zero flag. Register count and data width are parameters. It drives the bus select, the register-load enables and the ALU/memory strobes of the existing datapath.

## Interface
- `DW`, 16: data/IR width; must be ≥ 4+2·RW.
- `NREG`, 8: number of registers; power of two, ≥ 4. Register NREG-1 is the PC.
- `RW`, derived as log2(NREG): register field width.
- `SW`, derived as clog2(NREG+4): select width.
- `clk` in 1: the only clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: permits fetch of the next instruction.
- `IR` in DW: instruction register contents.
- `mem_ready` in 1: memory completes the current access this cycle.
- `z` in 1: zero flag, registered by the datapath on `g_in`.
- `select` out SW: bus source code.
- `Rin` out NREG: one-hot register load enable.
- `ir_in`, `a_in`, `g_in` out 1: IR, A and G load strobes.
- `alu_op` out 2: 0 add, 1 sub, 2 and, 3 pass.
- `addr_in`, `dout_in`, `w_d`, `incr_pc` out 1: memory address load, write-data load, write enable, PC increment.
- `done` out 1: the instruction completes in this cycle.

## Operation
- IR fields:
  - op = IR[DW-1:DW-3]; imm = IR[DW-4]; rX = next RW bits; rY = IR[RW-1:0].
  - The immediate is the low bits, extended by the datapath.
- Opcodes: 0 mv, 1 mvt, 2 add, 3 sub, 4 ld, 5 st, 6 and, 7 b.
- Select codes:
  - 0..NREG-1: registers.
  - NREG: G.
  - NREG+1: D (immediate).
  - NREG+2: DT (upper immediate).
  - NREG+3: DIN (memory read data).
- States: IDLE, FETCH, FWAIT, T1, T2, T3, MWAIT.
- IDLE: all outputs 0. Go to FETCH when `run`=1.
- FETCH: select=PC, `addr_in`=1, `incr_pc`=1. Go to FWAIT.
- FWAIT: hold until `mem_ready`. In the `mem_ready` cycle, `ir_in`=1 and the next state is T1.
- T1:
  - mv: select = imm?D:rY, Rin[rX], `done`.
  - mvt: select=DT, Rin[rX], `done`.
  - add/sub/and: select=rX, `a_in`; go to T2.
  - ld: select=rY, `addr_in`; go to MWAIT.
  - st: select=rY, `addr_in`; go to T2.
  - b: condition is taken from rX: 0 always, 1 z, 2 !z, others never.
    - Taken: select = imm?D:rY, Rin[NREG-1].
    - Either way: `done`.
- T2:
  - ALU ops: select = imm?D:rY, `g_in`, alu_op per opcode; go to T3.
  - st: select=rX, `dout_in`; go to MWAIT.
- T3: select=G, Rin[rX], `done`.
- MWAIT:
  - ld: hold until `mem_ready`. In that cycle, select=DIN, Rin[rX], `done`.
  - st: `w_d`=1 every cycle until and including the `mem_ready` cycle, then `done`.
- After any `done` cycle: next state is FETCH if `run`=1, otherwise IDLE.
- Outputs are a combinational decode of state and IR. Unlisted outputs are 0; select defaults to 0 and alu_op to 3.

## Timing
- Reset: state=IDLE immediately and asynchronously. Every output reads 0 (alu_op included) while `rst_n`=0 and afterwards until `run`.
- Reset mid-instruction: the instruction is abandoned with no further strobes; memory is not waited on.
- Latency from FETCH to done with zero wait (`mem_ready` constantly 1):
  - mv, mvt, b: 3 cycles.
  - add, sub, and: 5 cycles.
  - ld: 4 cycles.
  - st: 5 cycles.
- Each `mem_ready`-low cycle in FWAIT or MWAIT adds one cycle. `mem_ready` outside FWAIT/MWAIT is ignored.
- `run` is sampled only in IDLE and in `done` cycles. Dropping `run` mid-instruction never truncates the instruction.
- `done` is exactly one cycle per instruction. `ir_in` is exactly one cycle per fetch.
- mv/mvt/ld with rX=PC are legal jumps. `incr_pc` and `Rin[PC]` are never both asserted.

## Structure
- Package `proc_ctrl_pkg`: opcode enum, state enum, alu_op constants, and select-code functions of NREG (REG, G, D, DT, DIN).
- Sub-module `rin_decode` (parameter NREG): enable plus RW-bit index produces a one-hot `Rin`. It is used for both Rin[rX] and Rin[PC].
- FSM and output decode stay in `proc_ctrl_fsm`.

## Test plan
All scenarios use DW=16, NREG=8.
- **Reset mid-operation:** `rst_n` pulled low during T2 of add → all outputs 0 in the same cycle. After release with `run`=0, no FETCH occurs.
- **mv immediate:** IR=0x1605 (mv r3,#5), `mem_ready`=1 → T1 has select=9, Rin=0x08, `done`=1. FETCH follows the next cycle with select=7 and `incr_pc`=1.
- **add register:** IR=0x4202 (add r1,r2) →
  - T1: select=1, `a_in`.
  - T2: select=2, `g_in`, alu_op=0.
  - T3: select=8, Rin=0x02, `done`.
- **ld with wait:** IR=0x8805 (ld r4,[r5]), `mem_ready` low for 3 MWAIT cycles →
  - T1: select=5, `addr_in`.
  - 3 MWAIT cycles with all strobes 0.
  - Next cycle: select=11, Rin=0x10, `done`.
- **Branch:** IR=0xF420 (b ne,#0x20) →
  - z=0: select=9, Rin=0x80, `done`.
  - z=1: Rin=0, `done`.
- **run drop:** `run` dropped during T2 of sub (0x6202) → T3 still asserts Rin=0x02 and `done`. The FSM then enters IDLE with no `addr_in`.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared types and select-code helpers for the multi-cycle processor control unit.
package proc_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_MV, OP_MVT, OP_ADD, OP_SUB, OP_LD, OP_ST, OP_AND, OP_B
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_FWAIT, S_T1, S_T2, S_T3, S_MWAIT
   } state_e;

   localparam logic [1:0] ALU_ADD  = 2'd0;
   localparam logic [1:0] ALU_SUB  = 2'd1;
   localparam logic [1:0] ALU_AND  = 2'd2;
   localparam logic [1:0] ALU_PASS = 2'd3;

   // Bus source codes: registers occupy 0..NREG-1, the special sources follow.
   function automatic int sel_reg(input int r);
      return r;
   endfunction

   function automatic int sel_g(input int nreg);
      return nreg;
   endfunction

   function automatic int sel_d(input int nreg);
      return nreg + 1;
   endfunction

   function automatic int sel_dt(input int nreg);
      return nreg + 2;
   endfunction

   function automatic int sel_din(input int nreg);
      return nreg + 3;
   endfunction

endpackage

// File: rtl/proc_ctrl_fsm_if.sv
// Control/datapath boundary: instruction and status in, bus select and strobes out.
interface proc_ctrl_fsm_if #(
   parameter int DW   = 16,
   parameter int NREG = 8
);
   localparam int RW = $clog2(NREG);
   localparam int SW = $clog2(NREG + 4);

   logic            run;
   logic [DW-1:0]   IR;
   logic            mem_ready;
   logic            z;
   logic [SW-1:0]   select;
   logic [NREG-1:0] Rin;
   logic            ir_in;
   logic            a_in;
   logic            g_in;
   logic [1:0]      alu_op;
   logic            addr_in;
   logic            dout_in;
   logic            w_d;
   logic            incr_pc;
   logic            done;

   modport master (
      input  run, IR, mem_ready, z,
      output select, Rin, ir_in, a_in, g_in, alu_op,
             addr_in, dout_in, w_d, incr_pc, done
   );

   modport slave (
      output run, IR, mem_ready, z,
      input  select, Rin, ir_in, a_in, g_in, alu_op,
             addr_in, dout_in, w_d, incr_pc, done
   );
endinterface

// File: rtl/proc_ctrl_fsm_rin_decode.sv
// Register load-enable decoder: enable plus register index gives a one-hot Rin vector.
module rin_decode #(
   parameter int NREG = 8
) (
   input  logic                     en_i,
   input  logic [$clog2(NREG)-1:0]  idx_i,
   output logic [NREG-1:0]          onehot_o
);
   assign onehot_o = en_i ? (NREG'(1) << idx_i) : '0;
endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control FSM; outputs are a combinational decode of state and IR.
// Instruction latency 3..5 cycles, stretched one cycle per mem_ready-low wait cycle.
module proc_ctrl_fsm
   import proc_ctrl_pkg::*;
#(
   parameter int DW   = 16,
   parameter int NREG = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   proc_ctrl_fsm_if.master bus
);
   localparam int RW = $clog2(NREG);
   localparam int SW = $clog2(NREG + 4);

   localparam logic [SW-1:0] SEL_PC  = SW'(sel_reg(NREG - 1));
   localparam logic [SW-1:0] SEL_G   = SW'(sel_g(NREG));
   localparam logic [SW-1:0] SEL_D   = SW'(sel_d(NREG));
   localparam logic [SW-1:0] SEL_DT  = SW'(sel_dt(NREG));
   localparam logic [SW-1:0] SEL_DIN = SW'(sel_din(NREG));

   state_e state_q, state_d;

   opcode_e       op;
   logic          imm;
   logic [RW-1:0] rx, ry;
   logic [SW-1:0] rx_sel, ry_sel, op2_sel;
   logic          br_take;

   assign op      = opcode_e'(bus.IR[DW-1 -: 3]);
   assign imm     = bus.IR[DW-4];
   assign rx      = bus.IR[DW-5 -: RW];
   assign ry      = bus.IR[RW-1:0];
   assign rx_sel  = SW'(rx);
   assign ry_sel  = SW'(ry);
   assign op2_sel = imm ? SEL_D : ry_sel;

   // Branch condition is encoded in the rX field.
   always_comb begin
      br_take = 1'b0;
      case (rx)
         RW'(0):  br_take = 1'b1;
         RW'(1):  br_take = bus.z;
         RW'(2):  br_take = ~bus.z;
         default: br_take = 1'b0;
      endcase
   end

   logic [SW-1:0] select;
   logic [1:0]    alu_op;
   logic          ir_in, a_in, g_in, addr_in, dout_in, w_d, incr_pc, done;
   logic          rx_en, pc_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      select  = '0;
      alu_op  = ALU_PASS;
      ir_in   = 1'b0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      addr_in = 1'b0;
      dout_in = 1'b0;
      w_d     = 1'b0;
      incr_pc = 1'b0;
      done    = 1'b0;
      rx_en   = 1'b0;
      pc_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            alu_op = ALU_ADD;
            if (bus.run) state_d = S_FETCH;
         end
         S_FETCH: begin
            select  = SEL_PC;
            addr_in = 1'b1;
            incr_pc = 1'b1;
            state_d = S_FWAIT;
         end
         S_FWAIT: begin
            if (bus.mem_ready) begin
               ir_in   = 1'b1;
               state_d = S_T1;
            end
         end
         S_T1: begin
            case (op)
               OP_MV:  begin select = op2_sel; rx_en = 1'b1; done = 1'b1; end
               OP_MVT: begin select = SEL_DT;  rx_en = 1'b1; done = 1'b1; end
               OP_LD:  begin select = ry_sel; addr_in = 1'b1; state_d = S_MWAIT; end
               OP_ST:  begin select = ry_sel; addr_in = 1'b1; state_d = S_T2; end
               OP_B: begin
                  if (br_take) begin
                     select = op2_sel;
                     pc_en  = 1'b1;
                  end
                  done = 1'b1;
               end
               default: begin select = rx_sel; a_in = 1'b1; state_d = S_T2; end
            endcase
         end
         S_T2: begin
            case (op)
               OP_ST:  begin select = rx_sel; dout_in = 1'b1; state_d = S_MWAIT; end
               OP_ADD: begin select = op2_sel; g_in = 1'b1; alu_op = ALU_ADD; state_d = S_T3; end
               OP_SUB: begin select = op2_sel; g_in = 1'b1; alu_op = ALU_SUB; state_d = S_T3; end
               OP_AND: begin select = op2_sel; g_in = 1'b1; alu_op = ALU_AND; state_d = S_T3; end
               default: state_d = S_IDLE;
            endcase
         end
         S_T3: begin
            select = SEL_G;
            rx_en  = 1'b1;
            done   = 1'b1;
         end
         S_MWAIT: begin
            if (op == OP_LD) begin
               if (bus.mem_ready) begin
                  select = SEL_DIN;
                  rx_en  = 1'b1;
                  done   = 1'b1;
               end
            end else begin
               w_d  = 1'b1;
               done = bus.mem_ready;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (done) state_d = bus.run ? S_FETCH : S_IDLE;
   end

   logic [NREG-1:0] rin_rx, rin_pc;

   rin_decode #(.NREG(NREG)) u_rin_rx (
      .en_i     (rx_en),
      .idx_i    (rx),
      .onehot_o (rin_rx)
   );

   rin_decode #(.NREG(NREG)) u_rin_pc (
      .en_i     (pc_en),
      .idx_i    (RW'(NREG - 1)),
      .onehot_o (rin_pc)
   );

   assign bus.select  = select;
   assign bus.Rin     = rin_rx | rin_pc;
   assign bus.ir_in   = ir_in;
   assign bus.a_in    = a_in;
   assign bus.g_in    = g_in;
   assign bus.alu_op  = alu_op;
   assign bus.addr_in = addr_in;
   assign bus.dout_in = dout_in;
   assign bus.w_d     = w_d;
   assign bus.incr_pc = incr_pc;
   assign bus.done    = done;

endmodule
